rf_write_scheduler: RTL and testbench
=====================================

RF_WRITE_SCHEDULER -- requirements
Module: rf_write_scheduler

Interface
REQ-001 Parameter: DATA_W, default 32, width of write data.
REQ-002 Parameter: ADDR_W, default 5, register address width (2**ADDR_W registers).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req0_valid  input  1  ALU writeback request valid.
REQ-006 req0_addr  input  ADDR_W  ALU destination register.
REQ-007 req0_data  input  DATA_W  ALU result.
REQ-008 req0_ready  output  1  req0 accepted this cycle.
REQ-009 req1_valid / req1_addr / req1_data  input  1 / ADDR_W / DATA_W  memory-load writeback request; same meaning as req0.
REQ-010 req1_ready  output  1  req1 accepted this cycle.
REQ-011 rsv_valid, rsv_addr  input  1, ADDR_W  issue stage reserves a destination register.
REQ-012 q_a1, q_a2  input  ADDR_W  hazard-query addresses (issue stage source operands).
REQ-013 busy1, busy2  output  1  q_a1 / q_a2 has an outstanding write.
REQ-014 we3, a3, wd3  output  1, ADDR_W, DATA_W  registered register-file write port.

Function
REQ-015 Transfer on port n SHALL occur when reqn_valid and reqn_ready are both 1 in the same cycle.
REQ-016 At most one of req0_ready/req1_ready SHALL be 1 per cycle; ready SHALL be combinational from valids and priority state, never dependent on the other ready.
REQ-017 Single valid requester SHALL receive ready in that cycle (no bubbles).
REQ-018 Both valid: only the winner is granted; the loser SHALL hold valid/addr/data stable until granted.
REQ-019 Latency: the edge after a transfer SHALL load we3=1, a3=addr, wd3=data; a cycle without transfer SHALL load we3=0, with a3/wd3 holding.
REQ-020 Transfer with addr 0 SHALL be accepted (ready=1) but SHALL leave we3=0 (write dropped).
REQ-021 Scoreboard: one busy bit per register; bit 0 SHALL read 0 always.
REQ-022 rsv_valid with rsv_addr!=0 SHALL set busy[rsv_addr] at the next edge; re-reserving a busy register leaves it busy (no count).
REQ-023 busy[a3] SHALL clear at the edge where we3=1 is sampled (same edge the register file commits).
REQ-024 Set and clear of the same address on the same edge: set SHALL win.
REQ-025 busy1=busy[q_a1], busy2=busy[q_a2], combinational; no bypass of same-cycle reservation.
REQ-026 Priority state (round-robin mode): one-bit last-grant pointer, updated only on a contested or uncontested transfer to the granted port.

Reset
REQ-027 rst_n=0 SHALL immediately force we3=0, a3=0, wd3=0, all busy bits 0, req0_ready=req1_ready=0, pointer favouring req0.
REQ-028 Reset mid-operation SHALL discard any in-flight output write; after rst_n rises, first edge behaves as post-reset idle.

Configuration
REQ-029 Macro RF_SCHED_ROUND_ROBIN_EN defined: contested cycles granted to the port not granted last (req0 first after reset).
REQ-030 RF_SCHED_ROUND_ROBIN_EN undefined: fixed priority, req1 (load) always wins contention; pointer logic absent.

Verification
REQ-031 req0 valid alone, addr 7, data 0xDEADBEEF -> req0_ready=1 same cycle; next edge we3=1, a3=7, wd3=0xDEADBEEF; following cycle we3=0.
REQ-032 Both valid 3 cycles, addrs 3/4 -> RR build: grants req0,req1,req0; fixed build: req1 each cycle, req0 starved.
REQ-033 rsv 9, then req1 write to 9 -> busy1 (q_a1=9) high until edge sampling we3=1 with a3=9, then 0.
REQ-034 rsv_valid addr 5 on same edge we3=1, a3=5 -> busy[5] remains 1.
REQ-035 req0 addr 0 data 0x1234 -> ready=1, we3 stays 0; q_a1=0 -> busy1=0.
REQ-036 rst_n low while we3=1 and busy[12]=1 -> we3, busy1 (q_a1=12) fall without clock edge.

Source files
------------

// File: rtl/rf_write_scheduler_if.sv
// ---------------------------------------------------------------------------
// rf_write_scheduler_if
//   Bundles the writeback request ports, the issue-stage reservation and
//   hazard-query signals, and the registered register-file write port of
//   rf_write_scheduler.
//
//   master : the pipeline side (drives requests, reservations, queries)
//   slave  : the scheduler (returns readies, busy flags, write port)
//
//   req0_* : ALU writeback request   (valid/addr/data in, ready out)
//   req1_* : load writeback request  (valid/addr/data in, ready out)
//   rsv_*  : destination reservation from issue
//   q_a1/2 : hazard-query addresses, busy1/2 the matching scoreboard bits
//   we3/a3/wd3 : register-file write port
// ---------------------------------------------------------------------------
interface rf_write_scheduler_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              req0_valid;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_data;
    logic              req0_ready;

    logic              req1_valid;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_data;
    logic              req1_ready;

    logic              rsv_valid;
    logic [ADDR_W-1:0] rsv_addr;

    logic [ADDR_W-1:0] q_a1;
    logic [ADDR_W-1:0] q_a2;
    logic              busy1;
    logic              busy2;

    logic              we3;
    logic [ADDR_W-1:0] a3;
    logic [DATA_W-1:0] wd3;

    modport master (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        output rsv_valid, rsv_addr, q_a1, q_a2,
        input  req0_ready, req1_ready, busy1, busy2, we3, a3, wd3
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        input  rsv_valid, rsv_addr, q_a1, q_a2,
        output req0_ready, req1_ready, busy1, busy2, we3, a3, wd3
    );
endinterface

// File: rtl/rf_write_scheduler.sv
// ---------------------------------------------------------------------------
// rf_write_scheduler
//   Arbitrates two writeback sources (ALU = req0, load = req1) onto a single
//   registered register-file write port and keeps a per-register busy
//   scoreboard for issue-stage hazard detection.
//
//   Ports:
//     clk   : clock, all state on rising edge
//     rst_n : asynchronous active-low reset
//     bus   : rf_write_scheduler_if.slave (requests, reservations, queries,
//             write port)
//
//   Configuration macro:
//     RF_SCHED_ROUND_ROBIN_EN defined   -> contested cycles alternate,
//                                          req0 first after reset
//     RF_SCHED_ROUND_ROBIN_EN undefined -> fixed priority, load (req1) wins
//
//   Writes to register 0 are accepted but never reach the write port, and
//   busy bit 0 is hard-wired to 0.
// ---------------------------------------------------------------------------
module rf_write_scheduler #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input logic                 clk,
    input logic                 rst_n,
    rf_write_scheduler_if.slave bus
);
    localparam int NREG = 1 << ADDR_W;

    logic grant0;
    logic grant1;

    // Readies are forced low while reset is asserted, so a request can never
    // be consumed by a scheduler that is about to forget it.
`ifdef RF_SCHED_ROUND_ROBIN_EN
    typedef enum logic {
        LAST_REQ0 = 1'b0,
        LAST_REQ1 = 1'b1
    } last_grant_e;

    last_grant_e last_q;
    last_grant_e last_d;

    // NOTE: every signal assigned in always_comb gets a default on entry;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        last_d = last_q;
        if (rst_n) begin
            if (bus.req0_valid && bus.req1_valid) begin
                if (last_q == LAST_REQ1) grant0 = 1'b1;
                else                     grant1 = 1'b1;
            end else begin
                grant0 = bus.req0_valid;
                grant1 = bus.req1_valid;
            end
        end
        if (grant0)      last_d = LAST_REQ0;
        else if (grant1) last_d = LAST_REQ1;
    end

    // Reset value "req1 granted last" makes req0 win the first contest.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_q <= LAST_REQ1;
        else        last_q <= last_d;
    end
`else
    // NOTE: every signal assigned in always_comb gets a default on entry;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        grant1 = rst_n && bus.req1_valid;
        grant0 = rst_n && bus.req0_valid && !bus.req1_valid;
    end
`endif

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;

    // Selected transfer; the write is dropped when it targets register 0.
    logic              wr_fire;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    always_comb begin
        wr_addr = grant1 ? bus.req1_addr : bus.req0_addr;
        wr_data = grant1 ? bus.req1_data : bus.req0_data;
        wr_fire = (grant0 || grant1) && (wr_addr != '0);
    end

    logic              we3_q;
    logic [ADDR_W-1:0] a3_q;
    logic [DATA_W-1:0] wd3_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we3_q <= 1'b0;
            a3_q  <= '0;
            wd3_q <= '0;
        end else begin
            we3_q <= wr_fire;
            if (wr_fire) begin
                a3_q  <= wr_addr;
                wd3_q <= wr_data;
            end
        end
    end

    assign bus.we3 = we3_q;
    assign bus.a3  = a3_q;
    assign bus.wd3 = wd3_q;

    // Scoreboard: clear on the committing edge, set from a reservation.
    // The set is applied after the clear so a same-edge reservation wins.
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    always_comb begin
        busy_d = busy_q;
        if (we3_q) busy_d[a3_q] = 1'b0;
        if (bus.rsv_valid && (bus.rsv_addr != '0)) busy_d[bus.rsv_addr] = 1'b1;
        busy_d[0] = 1'b0;
    end

    // NOTE: the scoreboard is a flop vector rather than a RAM, so it can and
    // must be cleared by reset; a RAM array would not be reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_q <= '0;
        else        busy_q <= busy_d;
    end

    // Plain lookups: a reservation presented this cycle is not visible yet.
    assign bus.busy1 = busy_q[bus.q_a1];
    assign bus.busy2 = busy_q[bus.q_a2];

endmodule

// File: tb/tb_rf_write_scheduler.sv
// ---------------------------------------------------------------------------
// tb_rf_write_scheduler
//   Self-checking bench for rf_write_scheduler: directed scenarios followed by
//   randomized traffic compared against a behavioural model of the
//   arbitration, write-port and scoreboard rules. Build with or without
//   RF_SCHED_ROUND_ROBIN_EN; the model follows the same macro.
// ---------------------------------------------------------------------------
module tb_rf_write_scheduler;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREG   = 1 << ADDR_W;

    logic clk;
    logic rst_n;

    rf_write_scheduler_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    rf_write_scheduler #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", tag, $time, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    bit              m_we;
    bit [ADDR_W-1:0] m_a3;
    bit [DATA_W-1:0] m_wd3;
    bit [NREG-1:0]   m_busy;
    bit              m_g0, m_g1;     // model grants of the last cycle run
    bit              obs_r0, obs_r1; // DUT readies seen in that cycle
`ifdef RF_SCHED_ROUND_ROBIN_EN
    bit              m_last_req1;    // 1: req1 was the most recent grant
`endif

    task automatic model_reset();
        m_we = 0; m_a3 = '0; m_wd3 = '0; m_busy = '0;
        m_g0 = 0; m_g1 = 0;
`ifdef RF_SCHED_ROUND_ROBIN_EN
        m_last_req1 = 1;
`endif
    endtask

    task automatic idle_inputs();
        bus.req0_valid = 0; bus.req0_addr = '0; bus.req0_data = '0;
        bus.req1_valid = 0; bus.req1_addr = '0; bus.req1_data = '0;
        bus.rsv_valid  = 0; bus.rsv_addr  = '0;
        bus.q_a1 = '0; bus.q_a2 = '0;
    endtask

    // One clock cycle: compare everything at the negedge, then advance the
    // model across the rising edge. Returns at posedge + 1.
    task automatic run_cycle();
        bit g0, g1;
        bit n_we;
        bit [ADDR_W-1:0] n_a3, addr;
        bit [DATA_W-1:0] n_wd3, data;
        bit [NREG-1:0]   n_busy;
        @(negedge clk);
        g0 = 0; g1 = 0;
        if (bus.req0_valid && bus.req1_valid) begin
`ifdef RF_SCHED_ROUND_ROBIN_EN
            g0 = m_last_req1;
            g1 = !m_last_req1;
`else
            g1 = 1;
`endif
        end else begin
            g0 = bus.req0_valid;
            g1 = bus.req1_valid;
        end
        obs_r0 = bus.req0_ready;
        obs_r1 = bus.req1_ready;
        check("req0_ready", obs_r0, g0);
        check("req1_ready", obs_r1, g1);
        check("busy1", bus.busy1, m_busy[bus.q_a1]);
        check("busy2", bus.busy2, m_busy[bus.q_a2]);
        check("we3", bus.we3, m_we);
        check("a3", bus.a3, m_a3);
        check("wd3", bus.wd3, m_wd3);

        n_busy = m_busy;
        if (m_we) n_busy[m_a3] = 0;
        if (bus.rsv_valid && bus.rsv_addr != 0) n_busy[bus.rsv_addr] = 1;
        n_busy[0] = 0;
        n_we = 0; n_a3 = m_a3; n_wd3 = m_wd3;
        if (g0 || g1) begin
            addr = g1 ? bus.req1_addr : bus.req0_addr;
            data = g1 ? bus.req1_data : bus.req0_data;
            if (addr != 0) begin
                n_we = 1; n_a3 = addr; n_wd3 = data;
            end
        end
        @(posedge clk);
        #1;
        m_we = n_we; m_a3 = n_a3; m_wd3 = n_wd3; m_busy = n_busy;
        m_g0 = g0; m_g1 = g1;
`ifdef RF_SCHED_ROUND_ROBIN_EN
        if (g0)      m_last_req1 = 0;
        else if (g1) m_last_req1 = 1;
`endif
    endtask

    task automatic do_reset();
        rst_n = 0;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset between edges; outputs must drop with no clock edge.
    task automatic async_reset_check(input string tag);
        #2;
        bus.req0_valid = 1;
        bus.req1_valid = 1;
        rst_n = 0;
        #1;
        check({tag, "_we3"}, bus.we3, 0);
        check({tag, "_a3"}, bus.a3, 0);
        check({tag, "_wd3"}, bus.wd3, 0);
        check({tag, "_busy1"}, bus.busy1, 0);
        check({tag, "_busy2"}, bus.busy2, 0);
        check({tag, "_ready0"}, bus.req0_ready, 0);
        check({tag, "_ready1"}, bus.req1_ready, 0);
        idle_inputs();
        model_reset();
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [ADDR_W-1:0] rand_addr();
        if ($urandom_range(0, 1) == 1) return ADDR_W'($urandom_range(0, 7));
        return ADDR_W'($urandom);
    endfunction

    bit exp_r0 [3];

    initial begin
        rst_n = 0;
        idle_inputs();
        bus.req0_valid = 1;
        bus.req1_valid = 1;
        bus.q_a1 = 5'd9;
        #1;
        check("por_we3", bus.we3, 0);
        check("por_a3", bus.a3, 0);
        check("por_wd3", bus.wd3, 0);
        check("por_ready0", bus.req0_ready, 0);
        check("por_ready1", bus.req1_ready, 0);
        check("por_busy1", bus.busy1, 0);
        do_reset();

        // Single ALU write, no bubble, one-cycle latency, then idle.
        bus.req0_valid = 1; bus.req0_addr = 5'd7; bus.req0_data = 32'hDEADBEEF;
        run_cycle();
        check("t31_ready0", obs_r0, 1);
        check("t31_we3", bus.we3, 1);
        check("t31_a3", bus.a3, 7);
        check("t31_wd3", bus.wd3, 32'hDEADBEEF);
        idle_inputs();
        run_cycle();
        check("t31_we3_off", bus.we3, 0);
        check("t31_wd3_hold", bus.wd3, 32'hDEADBEEF);

        // Contention for three cycles from a fresh reset.
        do_reset();
`ifdef RF_SCHED_ROUND_ROBIN_EN
        exp_r0[0] = 1; exp_r0[1] = 0; exp_r0[2] = 1;
`else
        exp_r0[0] = 0; exp_r0[1] = 0; exp_r0[2] = 0;
`endif
        bus.req0_valid = 1; bus.req0_addr = 5'd3; bus.req0_data = 32'h0000_0A03;
        bus.req1_valid = 1; bus.req1_addr = 5'd4; bus.req1_data = 32'h0000_0B04;
        for (int i = 0; i < 3; i++) begin
            run_cycle();
            check($sformatf("t32_ready0_%0d", i), obs_r0, exp_r0[i]);
            check($sformatf("t32_ready1_%0d", i), obs_r1, !exp_r0[i]);
            check($sformatf("t32_a3_%0d", i), bus.a3, exp_r0[i] ? 3 : 4);
        end
        idle_inputs();
        run_cycle();

        // Reservation then load write: busy until the committing edge.
        bus.q_a1 = 5'd9;
        bus.rsv_valid = 1; bus.rsv_addr = 5'd9;
        run_cycle();
        bus.rsv_valid = 0;
        check("t33_busy_set", bus.busy1, 1);
        bus.req1_valid = 1; bus.req1_addr = 5'd9; bus.req1_data = 32'h9999_0009;
        run_cycle();
        bus.req1_valid = 0;
        check("t33_we3", bus.we3, 1);
        check("t33_busy_held", bus.busy1, 1);
        run_cycle();
        check("t33_busy_clr", bus.busy1, 0);

        // Re-reservation on the committing edge keeps the bit set.
        bus.q_a1 = 5'd5;
        bus.rsv_valid = 1; bus.rsv_addr = 5'd5;
        run_cycle();
        bus.rsv_valid = 0;
        bus.req0_valid = 1; bus.req0_addr = 5'd5; bus.req0_data = 32'h5555_0005;
        run_cycle();
        bus.req0_valid = 0;
        check("t34_we3", bus.we3, 1);
        bus.rsv_valid = 1; bus.rsv_addr = 5'd5;
        run_cycle();
        bus.rsv_valid = 0;
        check("t34_busy_kept", bus.busy1, 1);
        run_cycle();
        check("t34_busy_still", bus.busy1, 1);

        // Write to register 0: accepted, dropped; busy[0] reads 0.
        bus.q_a1 = 5'd0;
        bus.rsv_valid = 1; bus.rsv_addr = 5'd0;
        bus.req0_valid = 1; bus.req0_addr = 5'd0; bus.req0_data = 32'h0000_1234;
        run_cycle();
        idle_inputs();
        check("t35_ready0", obs_r0, 1);
        check("t35_we3", bus.we3, 0);
        check("t35_busy0", bus.busy1, 0);

        // Asynchronous reset with a write in flight and busy[12] set.
        bus.q_a1 = 5'd12;
        bus.rsv_valid = 1; bus.rsv_addr = 5'd12;
        run_cycle();
        bus.rsv_valid = 0;
        bus.req0_valid = 1; bus.req0_addr = 5'd12; bus.req0_data = 32'hC0DE_000C;
        run_cycle();
        check("t36_pre_we3", bus.we3, 1);
        check("t36_pre_busy", bus.busy1, 1);
        async_reset_check("t36");
        run_cycle();
        check("t36_post_we3", bus.we3, 0);

        // Randomized traffic; a refused requester holds its request.
        for (int c = 0; c < 600; c++) begin
            if (!(bus.req0_valid && !m_g0)) begin
                bus.req0_valid = ($urandom_range(0, 9) < 6);
                bus.req0_addr  = rand_addr();
                bus.req0_data  = $urandom;
            end
            if (!(bus.req1_valid && !m_g1)) begin
                bus.req1_valid = ($urandom_range(0, 9) < 5);
                bus.req1_addr  = rand_addr();
                bus.req1_data  = $urandom;
            end
            bus.rsv_valid = ($urandom_range(0, 9) < 3);
            bus.rsv_addr  = rand_addr();
            bus.q_a1      = rand_addr();
            bus.q_a2      = rand_addr();
            run_cycle();
            if (c == 300) async_reset_check("rnd_rst");
        end

        idle_inputs();
        run_cycle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
